// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the sequential shifter
// Purpose: mode and FSM state encodings used by seq_shift_unit and shift_step.
// Ports: none (package).
package shift_pkg;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-position shift step with ejected bit
// Purpose: combinational single-bit shift of the working value in the selected mode.
// Ports:
//   i_work  [WIDTH-1:0] current working value
//   i_mode  [1:0]       shift mode (shift_pkg MODE_*)
//   o_work  [WIDTH-1:0] working value after one step
//   o_eject             bit shifted out this step (always 0 for rotate)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_work,
  input  logic [1:0]       i_mode,
  output logic [WIDTH-1:0] o_work,
  output logic             o_eject
);

  always_comb begin
    o_work  = i_work;
    o_eject = 1'b0;
    case (i_mode)
      MODE_LSL: begin
        o_work  = {i_work[WIDTH-2:0], 1'b0};
        o_eject = i_work[WIDTH-1];
      end
      MODE_LSR: begin
        o_work  = {1'b0, i_work[WIDTH-1:1]};
        o_eject = i_work[0];
      end
      MODE_ASR: begin
        o_work  = {i_work[WIDTH-1], i_work[WIDTH-1:1]};
        o_eject = i_work[0];
      end
      MODE_ROR: begin
        // Rotation loses no information, so nothing feeds the sticky flag.
        o_work  = {i_work[0], i_work[WIDTH-1:1]};
        o_eject = 1'b0;
      end
      default: begin
        o_work  = i_work;
        o_eject = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle shifter, one bit position per clock
// Purpose: shifts In1 by Amount positions in one of four modes using a
//   Start/Busy/Done handshake, producing a registered result and sticky flag.
// Ports:
//   Clk                 system clock, rising edge
//   Reset               synchronous active-high reset
//   Start               request, sampled only while idle
//   Mode   [1:0]        00 LSL, 01 LSR, 10 ASR, 11 ROR
//   Amount [AMT_W-1:0]  number of positions to shift
//   In1    [WIDTH-1:0]  operand
//   Out    [WIDTH-1:0]  result, held until the next completion
//   Sticky              OR of all ejected bits, held with Out
//   Busy                high while an operation is in progress
//   Done                one-cycle pulse when Out/Sticky update
module seq_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [AMT_W-1:0] Amount,
  input  logic [WIDTH-1:0] In1,
  output logic [WIDTH-1:0] Out,
  output logic             Sticky,
  output logic             Busy,
  output logic             Done
);

  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] CNT_ZERO = '0;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_work;
  logic [AMT_W-1:0] r_cnt;
  logic [1:0]       r_mode;
  logic             r_stk;
  logic [WIDTH-1:0] r_out;
  logic             r_sticky;
  logic             r_done;

  logic [WIDTH-1:0] w_step_work;
  logic             w_step_eject;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == CNT_ZERO);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_work  (r_work),
    .i_mode  (r_mode),
    .o_work  (w_step_work),
    .o_eject (w_step_eject)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (Start)      w_next_state = ST_SHIFT;
      ST_SHIFT: if (w_cnt_zero) w_next_state = ST_IDLE;
      default:                  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_work   <= '0;
      r_cnt    <= '0;
      r_mode   <= MODE_LSL;
      r_stk    <= 1'b0;
      r_out    <= '0;
      r_sticky <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_work <= In1;
            r_cnt  <= Amount;
            r_mode <= Mode;
            r_stk  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!w_cnt_zero) begin
            r_work <= w_step_work;
            r_stk  <= r_stk | w_step_eject;
            r_cnt  <= r_cnt - CNT_ONE;
          end else begin
            r_out    <= r_work;
            r_sticky <= r_stk;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Out    = r_out;
  assign Sticky = r_sticky;
  assign Busy   = (r_state == ST_SHIFT);
  assign Done   = r_done;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - scoreboard bench for seq_shift_unit
// Purpose: directed vectors push expected results into a queue; a monitor pops
//   and compares result, sticky and completion cycle on every Done pulse.
// Ports: none (top-level bench).
module tb_seq_shift_unit;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  localparam logic [1:0] LSL = 2'b00;
  localparam logic [1:0] LSR = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             stk;
    logic [31:0]      cyc;
  } exp_t;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic [1:0]       Mode;
  logic [AMT_W-1:0] Amount;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] Out;
  logic             Sticky;
  logic             Busy;
  logic             Done;

  exp_t        sb[$];
  int          checks;
  int          errors;
  logic [31:0] cyc;

  seq_shift_unit #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Mode   (Mode),
    .Amount (Amount),
    .In1    (In1),
    .Out    (Out),
    .Sticky (Sticky),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = '0;
  always @(posedge Clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && Done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out", 32'(Out), 32'(e.out));
        check("sticky", 32'(Sticky), 32'(e.stk));
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns just after the accepting edge.
  task automatic run_op(input logic [WIDTH-1:0] in, input logic [1:0] md,
                        input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] eout,
                        input logic estk, input bit push);
    exp_t e;
    In1    = in;
    Mode   = md;
    Amount = amt;
    Start  = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    In1   = ~in;
    Mode  = ~md;
    if (push) begin
      e.out = eout;
      e.stk = estk;
      e.cyc = cyc + 32'(amt) + 32'd1;
      sb.push_back(e);
    end
  endtask

  // Leaves the caller at the negedge where Busy first reads low (the Done cycle).
  task automatic wait_idle(output int busy_cycles);
    bit ok;
    ok = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (!Busy) begin
        ok = 1'b1;
        break;
      end
      busy_cycles++;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bc;
    int done_seen;
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    Start  = 1'b1;
    Mode   = ASR;
    Amount = 3'd2;
    In1    = 8'hA5;

    // Reset held two clocks with Start high: nothing may start.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_out", 32'(Out), 32'h00);
    check("rst_sticky", 32'(Sticky), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    Start = 1'b0;
    @(negedge Clk);

    // Arithmetic right shifts.
    run_op(8'h96, ASR, 3'd1, 8'hCB, 1'b0, 1'b1);
    wait_idle(bc);
    check("busy_asr1", 32'(bc), 32'd2);
    run_op(8'h81, ASR, 3'd3, 8'hF0, 1'b1, 1'b1);
    wait_idle(bc);
    check("busy_asr3", 32'(bc), 32'd4);
    run_op(8'h80, ASR, 3'd7, 8'hFF, 1'b0, 1'b1);
    wait_idle(bc);

    // Remaining modes.
    run_op(8'h81, LSL, 3'd1, 8'h02, 1'b1, 1'b1);
    wait_idle(bc);
    run_op(8'h81, LSR, 3'd1, 8'h40, 1'b1, 1'b1);
    wait_idle(bc);
    run_op(8'h81, ROR, 3'd1, 8'hC0, 1'b0, 1'b1);
    wait_idle(bc);
    run_op(8'h81, ROR, 3'd7, 8'h03, 1'b0, 1'b1);
    wait_idle(bc);
    check("busy_ror7", 32'(bc), 32'd8);

    // Zero amount: pass-through after a single busy cycle.
    run_op(8'h5A, LSL, 3'd0, 8'h5A, 1'b0, 1'b1);
    wait_idle(bc);
    check("busy_amt0", 32'(bc), 32'd1);

    // Start pulsed mid-operation must be ignored.
    run_op(8'h10, LSR, 3'd4, 8'h01, 1'b0, 1'b1);
    @(negedge Clk);
    @(negedge Clk);
    In1    = 8'hFF;
    Mode   = LSL;
    Amount = 3'd1;
    Start  = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_idle(bc);

    // Now sitting in the Done cycle: a Start here is accepted.
    check("done_cycle_pulse", 32'(Done), 32'd1);
    run_op(8'h01, LSL, 3'd2, 8'h04, 1'b0, 1'b1);
    wait_idle(bc);
    check("busy_after_done_start", 32'(bc), 32'd3);

    // Reset in the middle of a shift aborts without a Done pulse.
    @(negedge Clk);
    run_op(8'hFF, LSL, 3'd5, 8'h00, 1'b0, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_busy", 32'(Busy), 32'd0);
    check("abort_out", 32'(Out), 32'h00);
    check("abort_sticky", 32'(Sticky), 32'd0);
    Reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (Done) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);

    // Normal operation afterwards.
    run_op(8'h96, ASR, 3'd2, 8'hE5, 1'b1, 1'b1);
    wait_idle(bc);
    check("busy_post_abort", 32'(bc), 32'd3);

    repeat (3) @(negedge Clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_shift_unit.md
Name: seq_shift_unit

Overview:
Parametrised multi-cycle shifter for the DSP datapath and the successor to the fixed 8-bit, single-position arithmetic right shift. It supports four shift modes, a runtime shift amount, and a sticky (shifted-out) flag for downstream rounding. It performs one bit-position per clock under a Start/Busy/Done handshake, so it can sit between the register file and the ALU result mux without a wide barrel array.

Parameters:
WIDTH, 8, data width in bits (>= 2)
AMT_W, 3, width of the shift-amount input; Amount may exceed WIDTH-1 when 2^AMT_W > WIDTH

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request; sampled only in IDLE
Mode  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right
Amount  input  AMT_W  number of bit positions to shift
In1  input  WIDTH  operand
Out  output  WIDTH  registered result, held until the next completion
Sticky  output  1  OR of all bits shifted out (0 in rotate mode), valid with Done and held with Out
Busy  output  1  high while an operation is in progress
Done  output  1  one-cycle pulse when Out/Sticky update

Behaviour:
- Clock and reset: single clock Clk. Reset is synchronous and active-high. Reset forces state IDLE and Out=0, Sticky=0, Done=0, Busy=0, and clears the internal working register and counter.
- Reset mid-operation: aborts the operation, leaves no Done pulse, and takes effect at that edge.
- States: IDLE and SHIFT. Busy = (state==SHIFT), decoded from the state register with no input path.
- IDLE, Start=1: capture In1 into work, Amount into cnt, Mode into mode_r, clear stk; next state SHIFT. Start=0: stay.
- SHIFT, cnt!=0: apply one step to work, OR the ejected bit into stk (except rotate), cnt<=cnt-1.
- SHIFT, cnt==0: Out<=work, Sticky<=stk, Done<=1, next state IDLE.
- Done is 1 only in the cycle after the completing edge; otherwise 0.
- Latency: Done rises Amount+1 clocks after the edge that accepted Start. Amount=0 therefore gives Done after 1 clock with Out=In1 and Sticky=0.
- Step definitions:
  - LSL: work<={work[W-2:0],0}; ejected bit work[W-1].
  - LSR: {0,work[W-1:1]}; ejected bit work[0].
  - ASR: {work[W-1],work[W-1:1]}; ejected bit work[0].
  - ROR: {work[0],work[W-1:1]}; no ejection.
- Amount >= WIDTH: iterate literally.
  - LSL/LSR: result 0.
  - ASR: result is all copies of the sign bit.
  - ROR: wraps modulo WIDTH.
  - Sticky: OR of all bits ejected.
- Start while Busy: ignored, with no queuing and no error.
- Start in the Done cycle: state is IDLE, so it is accepted. Back-to-back throughput is one operation per Amount+2 clocks.
- In1, Mode and Amount: may change freely after the accepting edge; only the captured copies are used.
- Out/Sticky: change only on completion or reset.

Decomposition:
- Shared package shift_pkg holds:
  - Mode encodings MODE_LSL=2'b00, MODE_LSR=2'b01, MODE_ASR=2'b10, MODE_ROR=2'b11.
  - State encodings ST_IDLE, ST_SHIFT.
- One natural combinational sub-module, shift_step: inputs work, mode; outputs next work and ejected bit. It is instantiated once, with the unit and bench parametrised by WIDTH.
- The FSM, counter and output registers stay in seq_shift_unit.

Test Plan:
1. Reset: hold Reset for 2 clocks with Start=1 -> Out=0x00, Sticky=0, Busy=0, Done=0. Start is ignored while Reset is high.
2. ASR cases:
   - In1=0x96, Amount=1 -> Done 2 clocks after accept, Out=0xCB, Sticky=0.
   - In1=0x81, Amount=3 -> Out=0xF0, Sticky=1.
   - In1=0x80, Amount=7 -> Out=0xFF, Sticky=0.
3. Other modes, In1=0x81, Amount=1:
   - LSL -> Out=0x02, Sticky=1.
   - LSR -> Out=0x40, Sticky=1.
   - ROR -> Out=0xC0, Sticky=0.
   - ROR with Amount=7 (8-bit, AMT_W=3) -> Out=0x03.
4. Amount=0: In1=0x5A -> Done after 1 clock, Out=0x5A, Sticky=0. Busy is high for exactly 1 cycle.
5. Handshake:
   - Start with In1=0x10, LSR, Amount=4; pulse Start again with In1=0xFF mid-operation -> second request ignored, Out=0x01.
   - New Start in the Done cycle -> accepted.
6. Reset mid-operation: assert Reset during SHIFT of Amount=5 -> no Done, Busy=0 next cycle, Out=0x00. A following operation behaves normally.
